div_req_sequencer: RTL and testbench

- Upstream issue stage and downstream result collector for the 12-stage pipelined non-restoring divider (13-bit dividend/divisor, 12-bit quotient).
- Accepts tagged division requests over a valid/ready handshake and drives the divider's operand and start inputs.
- Tracks each in-flight operation in a shadow pipeline matched to the divider latency.
- Captures each quotient into a tagged output FIFO with valid/ready; credit-based issue guarantees the FIFO never overflows, so the divider never needs to stall.

---
 rtl/div_req_sequencer.sv | 127 ++++++++++++
 tb/tb_div_req_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_sequencer.sv
// Issue/collect wrapper around a free-running pipelined divider: tagged requests go in,
// quotients return in order through a credit-protected output FIFO.
module div_req_sequencer #(
    parameter int TAG_W     = 4,
    parameter int DIV_LAT   = 11,
    parameter int OUT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [12:0]      req_dividend,
    input  logic [12:0]      req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [12:0]      div_dividend,
    output logic [12:0]      div_divisor,
    input  logic [11:0]      div_quotient,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [11:0]      rsp_quotient,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dz,
    output logic             busy
);

    // Stage 0 pairs with the operand register; DIV_LAT+1 further stages cover the divider.
    localparam int SH_LEN = DIV_LAT + 2;
    localparam int PW     = $clog2(OUT_DEPTH);
    localparam int CW     = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             dz;
    } shadow_t;

    typedef struct packed {
        logic [11:0]      quotient;
        logic [TAG_W-1:0] tag;
        logic             dz;
    } entry_t;

    shadow_t       shadow [SH_LEN];
    entry_t        mem    [OUT_DEPTH];
    entry_t        push_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] inflight_cnt;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] fifo_nxt;
    logic          accept;
    logic          push;
    logic          pop;

    // Credits count both in-flight ops and buffered results, so the FIFO can never overflow.
    assign req_ready = ~rst & (({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CW+1)'(OUT_DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = shadow[SH_LEN-1].valid;
    assign pop       = rsp_valid & rsp_ready;

    assign push_entry.quotient = shadow[SH_LEN-1].dz ? 12'hFFF : div_quotient;
    assign push_entry.tag      = shadow[SH_LEN-1].tag;
    assign push_entry.dz       = shadow[SH_LEN-1].dz;

    assign head         = mem[rd_ptr];
    assign rsp_quotient = head.quotient;
    assign rsp_tag      = head.tag;
    assign rsp_dz       = head.dz;

    always_comb begin
        // NOTE: defaults first so every path assigns both counts and no latch is inferred.
        inflight_nxt = inflight_cnt;
        fifo_nxt     = fifo_cnt;
        case ({accept, push})
            2'b10:   inflight_nxt = inflight_cnt + CW'(1);
            2'b01:   inflight_nxt = inflight_cnt - CW'(1);
            default: ;
        endcase
        case ({push, pop})
            2'b10:   fifo_nxt = fifo_cnt + CW'(1);
            2'b01:   fifo_nxt = fifo_cnt - CW'(1);
            default: ;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            for (int i = 0; i < SH_LEN; i++) shadow[i] <= '0;
            inflight_cnt <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rsp_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            div_start    <= 1'b1;
            div_dividend <= accept ? req_dividend : '0;
            div_divisor  <= accept ? req_divisor  : '0;
            shadow[0].valid <= accept;
            shadow[0].tag   <= accept ? req_tag : '0;
            shadow[0].dz    <= accept & (req_divisor == '0);
            for (int i = 1; i < SH_LEN; i++) shadow[i] <= shadow[i-1];
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            inflight_cnt <= inflight_nxt;
            fifo_cnt     <= fifo_nxt;
            rsp_valid    <= (fifo_nxt != '0);
            busy         <= (inflight_nxt != '0) | (fifo_nxt != '0);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_cnt == CW'(OUT_DEPTH)));

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a delay-line divider stub (quotient = dividend[11:0]).
module tb_div_req_sequencer;

    localparam int TAG_W   = 4;
    localparam int DIV_LAT = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [12:0]      req_dividend;
    logic [12:0]      req_divisor;
    logic [TAG_W-1:0] req_tag;
    logic             div_start;
    logic [12:0]      div_dividend;
    logic [12:0]      div_divisor;
    logic [11:0]      div_quotient;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [11:0]      rsp_quotient;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_dz;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    div_req_sequencer #(.TAG_W(TAG_W), .DIV_LAT(DIV_LAT), .OUT_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_tag      (req_tag),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_tag      (rsp_tag),
        .rsp_dz       (rsp_dz),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Divider stub: sampling register plus DIV_LAT further stages, advancing on div_start.
    logic [11:0] dq [DIV_LAT+1];
    always @(posedge clk) begin
        if (div_start) begin
            dq[0] <= div_dividend[11:0];
            for (int i = 1; i <= DIV_LAT; i++) dq[i] <= dq[i-1];
        end
    end
    assign div_quotient = dq[DIV_LAT];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (!rsp_valid && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic set_req(input logic v, input logic [12:0] dd, input logic [12:0] ds,
                           input logic [TAG_W-1:0] t);
        req_valid    = v;
        req_dividend = dd;
        req_divisor  = ds;
        req_tag      = t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int seen;
        logic rdy;

        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req(1'b0, '0, '0, '0);
        step();
        step();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_div_dividend", 32'(div_dividend), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        step();
        check("div_start_high", 32'(div_start), 32'd1);

        // Single request
        set_req(1'b1, 13'h0123, 13'd5, 4'd3);
        step();
        set_req(1'b0, '0, '0, '0);
        check("single_operand", 32'(div_dividend), 32'h123);
        check("single_busy", 32'(busy), 32'd1);
        wait_rsp(40, n);
        check("single_latency", 32'(n), 32'd13);
        check("single_quot", 32'(rsp_quotient), 32'h123);
        check("single_tag", 32'(rsp_tag), 32'd3);
        check("single_dz", 32'(rsp_dz), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("single_popped", 32'(rsp_valid), 32'd0);
        check("single_busy_drop", 32'(busy), 32'd0);

        // Back-to-back, no backpressure
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 13'(32'h100 + i), 13'd1, TAG_W'(i));
            check("b2b_ready", 32'(req_ready), 32'd1);
            step();
        end
        set_req(1'b0, '0, '0, '0);
        wait_rsp(40, n);
        check("b2b_latency", 32'(n), 32'd6);
        for (int k = 0; k < 8; k++) begin
            check("b2b_valid", 32'(rsp_valid), 32'd1);
            check("b2b_tag", 32'(rsp_tag), 32'(k));
            check("b2b_quot", 32'(rsp_quotient), 32'h100 + 32'(k));
            step();
        end
        check("b2b_empty", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Backpressure: credit limit
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            set_req(1'b1, 13'(32'h200 + acc), 13'd3, TAG_W'(acc));
            rdy = req_ready;
            step();
            if (rdy) acc++;
        end
        check("bp_accepts", 32'(acc), 32'd16);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_head_quot", 32'(rsp_quotient), 32'h200);
        check("bp_head_tag", 32'(rsp_tag), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_credit_back", 32'(req_ready), 32'd1);
        step();
        set_req(1'b0, '0, '0, '0);
        rsp_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wait_rsp(30, n);
            check("bp_drain_valid", 32'(rsp_valid), 32'd1);
            check("bp_drain_quot", 32'(rsp_quotient), 32'h200 + 32'(k));
            check("bp_drain_tag", 32'(rsp_tag), 32'(k % 16));
            step();
        end
        rsp_ready = 1'b0;
        check("bp_drained", 32'(rsp_valid), 32'd0);
        check("bp_idle", 32'(busy), 32'd0);

        // Divide by zero followed by a normal request
        set_req(1'b1, 13'h0042, 13'd0, 4'd9);
        step();
        set_req(1'b1, 13'h0055, 13'd2, 4'd10);
        step();
        set_req(1'b0, '0, '0, '0);
        wait_rsp(30, n);
        check("dz_quot", 32'(rsp_quotient), 32'hFFF);
        check("dz_tag", 32'(rsp_tag), 32'd9);
        check("dz_flag", 32'(rsp_dz), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("dz_next_valid", 32'(rsp_valid), 32'd1);
        check("dz_next_quot", 32'(rsp_quotient), 32'h055);
        check("dz_next_tag", 32'(rsp_tag), 32'd10);
        check("dz_next_flag", 32'(rsp_dz), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("dz_drained", 32'(rsp_valid), 32'd0);

        // Reset mid-flight discards everything
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 13'(32'h300 + i), 13'd7, TAG_W'(i));
            step();
        end
        set_req(1'b0, '0, '0, '0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        rsp_ready = 1'b0;
        set_req(1'b1, 13'h0ABC, 13'd4, 4'd5);
        step();
        set_req(1'b0, '0, '0, '0);
        wait_rsp(40, n);
        check("post_rst_latency", 32'(n), 32'd13);
        check("post_rst_quot", 32'(rsp_quotient), 32'hABC);
        check("post_rst_tag", 32'(rsp_tag), 32'd5);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Simultaneous push and pop with one entry held
        set_req(1'b1, 13'h0111, 13'd1, 4'd1);
        step();
        set_req(1'b1, 13'h0222, 13'd1, 4'd2);
        step();
        set_req(1'b0, '0, '0, '0);
        wait_rsp(40, n);
        check("pp_first_tag", 32'(rsp_tag), 32'd1);
        check("pp_cnt_before", 32'(dut.fifo_cnt), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("pp_cnt_after", 32'(dut.fifo_cnt), 32'd1);
        check("pp_valid", 32'(rsp_valid), 32'd1);
        check("pp_next_tag", 32'(rsp_tag), 32'd2);
        check("pp_next_quot", 32'(rsp_quotient), 32'h222);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("pp_empty", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
